// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg
// Shared definitions for the RV32I instruction encoder:
//   - fmt_e        : instruction format code carried on in_fmt (6/7 are illegal)
//   - OP_*         : base opcodes of the formats the encoder is used with
//   - NOP_INSTR    : canonical NOP (addi x0, x0, 0), emitted for rejected words
//   - IMM_*_MIN/MAX: signed immediate limits per format
//   - fmt_legal()  : format code is one of R/I/S/B/U/J
//   - imm_check_err(): range/alignment error for a (format, immediate) pair;
//                      only used by builds with ENC_RANGE_CHECK_EN defined
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_S_MIN = -2048;
  localparam int IMM_S_MAX = 2047;
  // B and J immediates are halfword offsets, so the top is one below 2^n - 1.
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  function automatic logic fmt_legal(input logic [2:0] fmt);
    return (fmt <= 3'd5);
  endfunction

  function automatic logic imm_check_err(input logic [2:0] fmt,
                                         input logic [31:0] imm);
    int   v;
    logic e;
    v = $signed(imm);
    e = 1'b0;
    case (fmt)
      FMT_R:   e = 1'b0;
      FMT_I:   e = (v < IMM_I_MIN) || (v > IMM_I_MAX);
      FMT_S:   e = (v < IMM_S_MIN) || (v > IMM_S_MAX);
      FMT_B:   e = (v < IMM_B_MIN) || (v > IMM_B_MAX) || imm[0];
      FMT_U:   e = (imm[11:0] != 12'h000);
      FMT_J:   e = (v < IMM_J_MIN) || (v > IMM_J_MAX) || imm[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
// Request and response channels of the instruction encoder.
//
// Handshake (both channels): a transfer happens on a rising clock edge where
// valid && ready are both 1. A producer holding valid=1 keeps valid and its
// payload unchanged until that transfer; ready may change freely and may
// depend combinationally on the other side's ready (in_ready follows
// out_ready within the same cycle).
//
// Request  (producer = master): in_valid, in_fmt, in_opcode, in_rd, in_rs1,
//                               in_rs2, in_funct3, in_funct7, in_imm / in_ready
// Response (producer = slave) : out_valid, out_instr, out_err / out_ready
interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

endinterface

// File: rtl/rv_imm_pack.sv
// rv_imm_pack
// Combinational immediate scatter: places the natural-value immediate into the
// instruction bit positions used by the given format. All positions that do
// not carry immediate bits are 0, so the result can be OR-ed with the
// register/funct/opcode fields.
//   fmt_i      [2:0]  format code (R/I/S/B/U/J, anything else gives 0)
//   imm_i      [31:0] immediate, natural value
//   imm_bits_o [31:0] immediate bit-field of the instruction word
// Out-of-range immediates are simply truncated; B/J drop bit 0.
module rv_imm_pack
  import rv_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [31:0] imm_i,
  output logic [31:0] imm_bits_o
);

  always_comb begin
    imm_bits_o = 32'h0;
    case (fmt_i)
      FMT_I: imm_bits_o = {imm_i[11:0], 20'h0};
      FMT_S: imm_bits_o = {imm_i[11:5], 13'h0, imm_i[4:0], 7'h0};
      FMT_B: imm_bits_o = {imm_i[12], imm_i[10:5], 13'h0,
                           imm_i[4:1], imm_i[11], 7'h0};
      FMT_U: imm_bits_o = {imm_i[31:12], 12'h0};
      FMT_J: imm_bits_o = {imm_i[20], imm_i[10:1], imm_i[11],
                           imm_i[19:12], 12'h0};
      default: imm_bits_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Two-stage pipelined RV32I instruction encoder. Takes decoded fields plus a
// natural-value immediate and emits the 32-bit instruction word.
//   S1: registers the fields, the format and the range-check result.
//   S2: registers the assembled word and its error flag.
// Full throughput, backpressure from out_ready, strict FIFO order.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   bus (slave)        request/response channels, see instr_encoder_if
//   enc_count [CNT_W]  completed output handshakes, wraps
//   err_count [8]      (ENC_RANGE_CHECK_EN only) emitted words with out_err=1,
//                      saturating at 255
//
// Build option ENC_RANGE_CHECK_EN: enables immediate range/alignment and
// format checks. A failing word is replaced by NOP_INSTR with out_err=1.
// Without it out_err is always 0 and immediates are truncated; an illegal
// format still produces NOP_INSTR.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] enc_count
`ifdef ENC_RANGE_CHECK_EN
  ,
  output logic [7:0]       err_count
`endif
);

  // Pipeline control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_load, s2_load;
  logic in_fire, out_fire;

  // S1 contents. Opcode bits [1:0] are always 2'b11 on output, so only
  // [6:2] is kept.
  logic [2:0]  s1_fmt_q;
  logic [4:0]  s1_opc_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [31:0] s1_imm_q;
  logic        s1_err_q;
  logic        in_err;

  // S2 contents
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q, s2_err_d;

  // Assembly between S1 and S2
  logic [31:0] imm_bits;
  logic [31:0] field_bits;
  logic [31:0] word;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A stage loads when it is empty or its word leaves this cycle.
  assign s2_load  = !s2_valid_q || bus.out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_fire  = bus.in_valid && s1_load;
  assign out_fire = s2_valid_q && bus.out_ready;

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_err   = s2_err_q;
  assign enc_count     = cnt_q;

`ifdef ENC_RANGE_CHECK_EN
  assign in_err = imm_check_err(bus.in_fmt, bus.in_imm);
`else
  assign in_err = 1'b0;
`endif

  // ---------------------------------------------------------------- S1
  assign s1_valid_d = s1_load ? bus.in_valid : s1_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= 3'h0;
      s1_opc_q    <= 5'h0;
      s1_rd_q     <= 5'h0;
      s1_rs1_q    <= 5'h0;
      s1_rs2_q    <= 5'h0;
      s1_funct3_q <= 3'h0;
      s1_funct7_q <= 7'h0;
      s1_imm_q    <= 32'h0;
      s1_err_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_fmt_q    <= bus.in_fmt;
        s1_opc_q    <= bus.in_opcode[6:2];
        s1_rd_q     <= bus.in_rd;
        s1_rs1_q    <= bus.in_rs1;
        s1_rs2_q    <= bus.in_rs2;
        s1_funct3_q <= bus.in_funct3;
        s1_funct7_q <= bus.in_funct7;
        s1_imm_q    <= bus.in_imm;
        s1_err_q    <= in_err;
      end
    end
  end

  // ------------------------------------------------------- word assembly
  rv_imm_pack u_imm_pack (
    .fmt_i      (s1_fmt_q),
    .imm_i      (s1_imm_q),
    .imm_bits_o (imm_bits)
  );

  // Only the register/funct fields the format owns are placed; the rest
  // stay 0 so stale or garbage inputs never reach the word.
  always_comb begin
    field_bits = 32'h0;
    case (s1_fmt_q)
      FMT_R: field_bits = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q,
                           s1_rd_q, 7'h0};
      FMT_I: field_bits = {12'h0, s1_rs1_q, s1_funct3_q, s1_rd_q, 7'h0};
      FMT_S,
      FMT_B: field_bits = {7'h0, s1_rs2_q, s1_rs1_q, s1_funct3_q,
                           5'h0, 7'h0};
      FMT_U,
      FMT_J: field_bits = {20'h0, s1_rd_q, 7'h0};
      default: field_bits = 32'h0;
    endcase
  end

  always_comb begin
    word = field_bits | imm_bits | {25'h0, s1_opc_q, 2'b11};
    if (s1_err_q || !fmt_legal(s1_fmt_q)) begin
      word = NOP_INSTR;
    end
  end

  // ---------------------------------------------------------------- S2
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      // Data only changes when a real word moves in, keeping the output
      // bus quiet while the pipeline drains.
      if (s1_valid_q) begin
        s2_instr_d = word;
        s2_err_d   = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'h0;
      s2_err_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
    end
  end

  // ------------------------------------------------------------ counters
  assign cnt_d = out_fire ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_fire && s2_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Directed bench for instr_encoder. Expected words are hand-computed RV32I
// encodings. Builds with or without ENC_RANGE_CHECK_EN.
module tb_instr_encoder;
  import rv_enc_pkg::*;

  localparam int CNT_W = 16;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  // ------------------------------------------------ clock / reset / DUT
  logic clk;
  logic rst_n;
  logic [CNT_W-1:0] enc_count;
`ifdef ENC_RANGE_CHECK_EN
  logic [7:0] err_count;
`endif

  instr_encoder_if bus ();

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .enc_count (enc_count)
`ifdef ENC_RANGE_CHECK_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------ scoreboard
  int          n_vec   = 0;
  int          n_fail  = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_q[$];
  vec_t        bb[4];

  logic [31:0] got_instr;
  logic        got_err;
  int          got_lat;

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] opc,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] exp);
    vec_t v;
    v.fmt = fmt; v.opc = opc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp = exp;
    return v;
  endfunction

  // ------------------------------------------------------ driver tasks
  task automatic drive(input vec_t v);
    bus.in_fmt    = v.fmt;
    bus.in_opcode = v.opc;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_funct3 = v.f3;
    bus.in_funct7 = v.f7;
    bus.in_imm    = v.imm;
  endtask

  // Sends one request with out_ready=1 and captures the resulting word.
  // lat counts negedges after the accepting edge until out_valid; -1 = none.
  task automatic apply(input vec_t v, output logic [31:0] instr,
                       output logic err, output int lat);
    logic acc;
    instr = 32'hx; err = 1'bx; lat = -1; acc = 1'b0;
    @(posedge clk); #1;
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (acc) begin
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          lat   = i;
          instr = bus.out_instr;
          err   = bus.out_err;
          break;
        end
      end
    end
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(mk(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 32'h0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid_in_reset: got %b expected 0", bus.out_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_vec++;
    if (bus.out_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_instr: got %h expected 00000000", bus.out_instr);
    end
    n_vec++;
    if (bus.out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_err: got %b expected 0", bus.out_err);
    end
    n_vec++;
    if (enc_count !== '0) begin
      n_fail++; $display("FAIL reset_enc_count: got %0d expected 0", enc_count);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_i_type;
    // addi x1, x0, -1
    apply(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,
             32'hFFF0_0093), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'hFFF0_0093) begin
      n_fail++; $display("FAIL i_type_instr: got %h expected fff00093", got_instr);
    end
    n_vec++;
    if (got_err !== 1'b0) begin
      n_fail++; $display("FAIL i_type_err: got %b expected 0", got_err);
    end
    n_vec++;
    if (got_lat !== 2) begin
      n_fail++; $display("FAIL i_type_latency: got %0d expected 2", got_lat);
    end
  endtask

  task automatic test_s_type;
    // sw x2, 8(x1); rd carries garbage that S must ignore
    apply(mk(FMT_S, 7'h23, 5'd7, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,
             32'h0020_A423), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'h0020_A423) begin
      n_fail++; $display("FAIL s_type_instr: got %h expected 0020a423", got_instr);
    end
  endtask

  task automatic test_b_j_type;
    // beq x0, x0, -4; rd garbage
    apply(mk(FMT_B, 7'h63, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC,
             32'hFE00_0EE3), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'hFE00_0EE3) begin
      n_fail++; $display("FAIL b_type_instr: got %h expected fe000ee3", got_instr);
    end
    // B upper boundary 4094
    apply(mk(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,
             32'h7E00_0FE3), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'h7E00_0FE3 || got_err !== 1'b0) begin
      n_fail++; $display("FAIL b_type_max: got %h/%b expected 7e000fe3/0", got_instr, got_err);
    end
    // jal x1, 2048; rs1 garbage
    apply(mk(FMT_J, 7'h6F, 5'd1, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2048,
             32'h0010_00EF), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'h0010_00EF) begin
      n_fail++; $display("FAIL j_type_instr: got %h expected 001000ef", got_instr);
    end
  endtask

  task automatic test_unused_fields;
    // sub x3, x1, x2 with opcode low bits clear and a random unused imm
    apply(mk(FMT_R, 7'h30, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, $urandom(),
             32'h4020_81B3), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'h4020_81B3 || got_err !== 1'b0) begin
      n_fail++; $display("FAIL r_type_unused_imm: got %h/%b expected 402081b3/0", got_instr, got_err);
    end
    // addi x2, x3, 5 with random rs2/funct7
    apply(mk(FMT_I, 7'h13, 5'd2, 5'd3, 5'($urandom_range(31, 0)), 3'd0,
             7'($urandom_range(127, 0)), 32'd5, 32'h0051_8113),
          got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'h0051_8113) begin
      n_fail++; $display("FAIL i_type_unused_fields: got %h expected 00518113", got_instr);
    end
    // lui x5, 0x12345 with random rs1/rs2/funct3/funct7
    apply(mk(FMT_U, 7'h37, 5'd5, 5'($urandom_range(31, 0)),
             5'($urandom_range(31, 0)), 3'($urandom_range(7, 0)),
             7'($urandom_range(127, 0)), 32'h1234_5000, 32'h1234_52B7),
          got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'h1234_52B7 || got_err !== 1'b0) begin
      n_fail++; $display("FAIL u_type_unused_fields: got %h/%b expected 123452b7/0", got_instr, got_err);
    end
  endtask

  task automatic test_errors;
    // I lower boundary -2048 is legal in every build
    apply(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,
             32'h8000_0093), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'h8000_0093 || got_err !== 1'b0) begin
      n_fail++; $display("FAIL i_type_min: got %h/%b expected 80000093/0", got_instr, got_err);
    end
`ifdef ENC_RANGE_CHECK_EN
    apply(mk(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,
             NOP_INSTR), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== NOP_INSTR || got_err !== 1'b1) begin
      n_fail++; $display("FAIL err_b_misaligned: got %h/%b expected 00000013/1", got_instr, got_err);
    end
    apply(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
             NOP_INSTR), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== NOP_INSTR || got_err !== 1'b1) begin
      n_fail++; $display("FAIL err_i_range: got %h/%b expected 00000013/1", got_instr, got_err);
    end
    apply(mk(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,
             NOP_INSTR), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== NOP_INSTR || got_err !== 1'b1) begin
      n_fail++; $display("FAIL err_illegal_fmt: got %h/%b expected 00000013/1", got_instr, got_err);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (err_count !== 8'd3) begin
      n_fail++; $display("FAIL err_count: got %0d expected 3", err_count);
    end
`else
    // Without checks: bit 0 dropped, high bits truncated, illegal fmt -> NOP
    apply(mk(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,
             32'h0000_0163), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'h0000_0163 || got_err !== 1'b0) begin
      n_fail++; $display("FAIL nochk_b_misaligned: got %h/%b expected 00000163/0", got_instr, got_err);
    end
    apply(mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
             32'h8000_0093), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== 32'h8000_0093 || got_err !== 1'b0) begin
      n_fail++; $display("FAIL nochk_i_truncate: got %h/%b expected 80000093/0", got_instr, got_err);
    end
    apply(mk(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,
             NOP_INSTR), got_instr, got_err, got_lat);
    exp_cnt++;
    n_vec++;
    if (got_instr !== NOP_INSTR || got_err !== 1'b0) begin
      n_fail++; $display("FAIL nochk_illegal_fmt: got %h/%b expected 00000013/0", got_instr, got_err);
    end
`endif
  endtask

  task automatic test_enc_count;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (enc_count !== CNT_W'(exp_cnt)) begin
      n_fail++; $display("FAIL enc_count_directed: got %0d expected %0d", enc_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int sent, got, stalls, first_c, last_c;
    exp_q.delete();
    sent = 0; got = 0; stalls = 0; first_c = -1; last_c = -1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 16 && got < 4; c++) begin
      if (sent < 4) begin
        drive(bb[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bb[sent].exp);
        sent++;
      end else if (bus.in_valid) begin
        stalls++;
      end
      if (bus.out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected_word: got %h expected none", bus.out_instr);
        end else if (bus.out_instr !== exp_q[0]) begin
          n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", got, bus.out_instr, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
        exp_cnt++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (got !== 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 4", got);
    end
    n_vec++;
    if (stalls !== 0) begin
      n_fail++; $display("FAIL b2b_in_ready_stalls: got %0d expected 0", stalls);
    end
    n_vec++;
    if (last_c - first_c !== 3) begin
      n_fail++; $display("FAIL b2b_throughput_span: got %0d expected 3", last_c - first_c);
    end
  endtask

  task automatic test_backpressure;
    int  sent, got;
    logic first;
    exp_q.delete();
    sent = 0; got = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (sent < 3) begin
        drive(bb[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bb[sent].exp);
        sent++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_vec++;
    if (sent !== 2) begin
      n_fail++; $display("FAIL bp_accepted_while_stalled: got %0d expected 2", sent);
    end
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready_full: got %b expected 0", bus.in_ready);
    end
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== bb[0].exp) begin
      n_fail++; $display("FAIL bp_held_word: got %b/%h expected 1/%h", bus.out_valid, bus.out_instr, bb[0].exp);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    first = 1'b1;
    for (int c = 0; c < 16 && got < 3; c++) begin
      if (sent < 3) begin
        drive(bb[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (first) begin
        // Both stages full and draining: the pipeline shifts and accepts.
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++; $display("FAIL bp_shift_in_ready: got %b expected 1", bus.in_ready);
        end
        first = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bb[sent].exp);
        sent++;
      end
      if (bus.out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_unexpected_word: got %h expected none", bus.out_instr);
        end else if (bus.out_instr !== exp_q[0]) begin
          n_fail++; $display("FAIL bp_word%0d: got %h expected %h", got, bus.out_instr, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        got++;
        exp_cnt++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (got !== 3) begin
      n_fail++; $display("FAIL bp_drained: got %0d expected 3", got);
    end
    @(negedge clk);
    n_vec++;
    if (enc_count !== CNT_W'(exp_cnt)) begin
      n_fail++; $display("FAIL bp_enc_count: got %0d expected %0d", enc_count, exp_cnt);
    end
  endtask

  task automatic test_reset_midflight;
    int stale;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive(bb[0]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(bb[1]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_precondition: got %b expected 1", bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_out_valid_async: got %b expected 0", bus.out_valid);
    end
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    n_vec++;
    if (stale !== 0) begin
      n_fail++; $display("FAIL midrst_stale_words: got %0d expected 0", stale);
    end
    n_vec++;
    if (enc_count !== CNT_W'(exp_cnt)) begin
      n_fail++; $display("FAIL midrst_enc_count: got %0d expected 0", enc_count);
    end
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    bb[0] = mk(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,        32'h0010_0093);
    bb[1] = mk(FMT_I, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFE, 32'hFFE0_8113);
    bb[2] = mk(FMT_U, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 32'hABCD_E1B7);
    bb[3] = mk(FMT_S, 7'h23, 5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE53_2E23);

    test_reset();
    test_i_type();
    test_s_type();
    test_b_j_type();
    test_unused_fields();
    test_errors();
    test_enc_count();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
